// File: rtl/coherence_pkg.sv
// Shared definitions for the coherence hub: default widths and the legacy
// 25-bit change-packet layout {valid, tag, addr}.
package coherence_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int TAG_W_DEF     = 8;

  // Field offsets of the existing {1, 8, 16} change packet.
  localparam int PKT_ADDR_LSB  = 0;
  localparam int PKT_TAG_LSB   = PKT_ADDR_LSB + ADDR_W_DEF;
  localparam int PKT_VALID_BIT = PKT_TAG_LSB + TAG_W_DEF;
  localparam int PKT_W         = PKT_VALID_BIT + 1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [ADDR_W_DEF-1:0] addr;
  } chg_pkt_t;

  // k-th candidate of a round-robin search that starts just after cur.
  function automatic int rr_next(input int cur, input int k, input int n);
    return (cur + 1 + k) % n;
  endfunction

endpackage

// File: rtl/coh_fifo.sv
// Per-core pending-change FIFO. Pointers carry an extra wrap bit so full and
// empty are told apart without a separate counter.
module coh_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_data = mem[rptr[AW-1:0]];

  // Pointer advance; the wrap bit flips each lap of the storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: empty pointers mask stale contents.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cache_coherence_hub.sv
// Coherence hub: per-core change FIFOs, round-robin arbiter and a single
// registered invalidate broadcast to every other core.
module cache_coherence_hub
  import coherence_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DEPTH     = 4,
  parameter int INV_SELF  = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CORES-1:0]         chg_valid,
  input  logic [NUM_CORES*TAG_W-1:0]   chg_tag,
  input  logic [NUM_CORES*ADDR_W-1:0]  chg_addr,
  output logic [NUM_CORES-1:0]         chg_ready,
  output logic [NUM_CORES-1:0]         inv_valid,
  output logic [ADDR_W-1:0]            inv_addr,
  output logic [TAG_W-1:0]             inv_tag,
  output logic [$clog2(NUM_CORES)-1:0] inv_src,
  output logic [NUM_CORES-1:0]         overflow
);

  localparam int SW = $clog2(NUM_CORES);
  localparam int W  = TAG_W + ADDR_W;

  logic [NUM_CORES-1:0]        full, empty, push, pop, inv_mask;
  logic [NUM_CORES-1:0][W-1:0] head;
  logic [SW-1:0]               last_grant, gnt_idx;
  logic                        gnt_vld;

  assign chg_ready = {NUM_CORES{reset}} & ~full;
  assign push      = chg_valid & chg_ready;

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_fifo
      coh_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push[i]),
        .pop     (pop[i]),
        .wr_data ({chg_tag[i*TAG_W +: TAG_W], chg_addr[i*ADDR_W +: ADDR_W]}),
        .rd_data (head[i]),
        .full    (full[i]),
        .empty   (empty[i])
      );
    end
  endgenerate

  // Round-robin pick: first non-empty FIFO after the last granted core.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!gnt_vld && !empty[rr_next(int'(last_grant), k, NUM_CORES)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(rr_next(int'(last_grant), k, NUM_CORES));
      end
    end
  end

  // Pop the winner's head on the granting edge.
  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  // Invalidate targets: everyone, with the source bit set by INV_SELF.
  always_comb begin
    inv_mask          = '1;
    inv_mask[gnt_idx] = (INV_SELF != 0);
  end

  // Last grant resets to the top core so core 0 is searched first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       last_grant <= SW'(NUM_CORES - 1);
    else if (gnt_vld) last_grant <= gnt_idx;
  end

  // Broadcast register: strobe for one cycle, payload holds between grants.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inv_valid <= '0;
      inv_addr  <= '0;
      inv_tag   <= '0;
      inv_src   <= '0;
    end else begin
      inv_valid <= gnt_vld ? inv_mask : '0;
      if (gnt_vld) begin
        inv_addr <= head[gnt_idx][ADDR_W-1:0];
        inv_tag  <= head[gnt_idx][W-1:ADDR_W];
        inv_src  <= gnt_idx;
      end
    end
  end

  // Sticky drop flag: a valid offered to a full FIFO is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow <= '0;
    else        overflow <= overflow | (chg_valid & ~chg_ready);
  end

endmodule

// File: tb/tb_cache_coherence_hub.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cache_coherence_hub;

  localparam int N = 4, AW = 16, TW = 8, D = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    chg_valid, chg_ready, inv_valid, overflow;
  logic [N*TW-1:0] chg_tag;
  logic [N*AW-1:0] chg_addr;
  logic [AW-1:0]   inv_addr;
  logic [TW-1:0]   inv_tag;
  logic [1:0]      inv_src;

  logic [N-1:0]    d2_valid, d2_ready, d2_inv_valid, d2_overflow;
  logic [N*TW-1:0] d2_tag;
  logic [N*AW-1:0] d2_addr;
  logic [AW-1:0]   d2_inv_addr;
  logic [TW-1:0]   d2_inv_tag;
  logic [1:0]      d2_inv_src;

  cache_coherence_hub #(.NUM_CORES(N), .ADDR_W(AW), .TAG_W(TW), .DEPTH(D), .INV_SELF(0)) dut (
    .clock(clock), .reset(rst_n), .chg_valid(chg_valid), .chg_tag(chg_tag),
    .chg_addr(chg_addr), .chg_ready(chg_ready), .inv_valid(inv_valid),
    .inv_addr(inv_addr), .inv_tag(inv_tag), .inv_src(inv_src), .overflow(overflow));

  cache_coherence_hub #(.NUM_CORES(N), .ADDR_W(AW), .TAG_W(TW), .DEPTH(D), .INV_SELF(1)) dut_self (
    .clock(clock), .reset(rst_n), .chg_valid(d2_valid), .chg_tag(d2_tag),
    .chg_addr(d2_addr), .chg_ready(d2_ready), .inv_valid(d2_inv_valid),
    .inv_addr(d2_inv_addr), .inv_tag(d2_inv_tag), .inv_src(d2_inv_src), .overflow(d2_overflow));

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: per-core circular queues plus last-granted core.
  logic [23:0]  mq [N][16];
  int           hd [N];
  int           cnt [N];
  int           lg, g;
  bit           found;
  logic [N-1:0] acc, m_inv, m_ovf, exp_ready;
  logic [23:0]  e;
  logic [15:0]  m_addr;
  logic [7:0]   m_tag;
  logic [1:0]   m_src;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin cnt[i] = 0; hd[i] = 0; end
      lg = N - 1; m_inv = '0; m_ovf = '0; m_addr = '0; m_tag = '0; m_src = '0;
    end else begin
      found = 1'b0; g = 0;
      for (int k = 0; k < N; k++)
        if (!found && cnt[(lg + 1 + k) % N] > 0) begin found = 1'b1; g = (lg + 1 + k) % N; end
      for (int i = 0; i < N; i++) begin
        acc[i] = chg_valid[i] && (cnt[i] < D);
        if (chg_valid[i] && cnt[i] >= D) m_ovf[i] = 1'b1;
      end
      if (found) begin
        e = mq[g][hd[g]];
        hd[g] = (hd[g] + 1) % 16; cnt[g] = cnt[g] - 1;
        m_addr = e[15:0]; m_tag = e[23:16]; m_src = 2'(g);
        m_inv = 4'hF & ~(4'b0001 << g);
        lg = g;
      end else m_inv = '0;
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          mq[i][(hd[i] + cnt[i]) % 16] = {chg_tag[i*TW +: TW], chg_addr[i*AW +: AW]};
          cnt[i] = cnt[i] + 1;
        end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) exp_ready[i] = rst_n && (cnt[i] < D);
      check("m_ready", chg_ready, exp_ready);
      check("m_inv_valid", inv_valid, m_inv);
      check("m_inv_addr", inv_addr, m_addr);
      check("m_inv_tag", inv_tag, m_tag);
      check("m_inv_src", inv_src, m_src);
      check("m_overflow", overflow, m_ovf);
    end
  end

  task automatic drive(input int c, input logic [15:0] a, input logic [7:0] t);
    chg_valid[c] = 1'b1;
    chg_addr[c*AW +: AW] = a;
    chg_tag[c*TW +: TW] = t;
  endtask

  task automatic do_reset();
    @(negedge clock);
    chg_valid = '0; d2_valid = '0;
    #2 rst_n = 1'b0;
    @(negedge clock);
    check("rst_ready", chg_ready, 0);
    check("rst_inv_valid", inv_valid, 0);
    #2 rst_n = 1'b1;
    @(negedge clock);
  endtask

  logic [15:0] seen[$];
  int nb;

  initial begin
    chg_valid = '0; chg_tag = '0; chg_addr = '0;
    d2_valid = '0; d2_tag = '0; d2_addr = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ready0", chg_ready, 0);
    check("rst_valid0", inv_valid, 0);
    check("rst_addr0", inv_addr, 0);
    check("rst_ovf0", overflow, 0);
    cmp_en = 1'b1;
    #2 rst_n = 1'b1;

    // Single change from core 0.
    do_reset();
    drive(0, 16'd100, 8'd123);
    @(negedge clock); chg_valid = '0;
    @(negedge clock);
    check("single_valid", inv_valid, 4'b1110);
    check("single_addr", inv_addr, 100);
    check("single_tag", inv_tag, 123);
    check("single_src", inv_src, 0);
    @(negedge clock);
    check("single_once", inv_valid, 0);

    // All four cores on the same edge.
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 16'(10 * (i + 1)), 8'(i));
    @(negedge clock); chg_valid = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      check("simul_src", inv_src, i);
      check("simul_valid", inv_valid, 4'hF & ~(4'b0001 << i));
      check("simul_addr", inv_addr, 10 * (i + 1));
    end

    // Fairness: cores 1 and 2 push whenever ready.
    do_reset();
    nb = 0;
    repeat (20) begin
      chg_valid = 4'b0110 & chg_ready;
      chg_addr[31:16] = 16'($urandom);
      chg_addr[47:32] = 16'($urandom);
      @(negedge clock);
      if (inv_valid != 0) begin
        check("fair_src", inv_src, (nb % 2 == 0) ? 1 : 2);
        nb++;
      end
    end
    chg_valid = '0;
    check("fair_count", nb, 19);
    check("fair_ovf", overflow, 0);
    repeat (12) @(negedge clock);

    // Fill core 3 while cores 0..2 take the first grants.
    do_reset();
    drive(0, 16'h00A0, 8'h01); drive(1, 16'h00B0, 8'h02); drive(2, 16'h00C0, 8'h03);
    drive(3, 16'h3000, 8'h30);
    @(negedge clock); chg_valid[2:0] = '0; chg_addr[63:48] = 16'h3001;
    @(negedge clock); chg_addr[63:48] = 16'h3002;
    @(negedge clock); chg_addr[63:48] = 16'h3003;
    @(negedge clock);
    check("full_ready3", chg_ready[3], 0);
    chg_addr[63:48] = 16'hBEEF;
    @(negedge clock); chg_valid = '0;
    check("ovf3", overflow, 4'b1000);
    for (int k = 0; k < 10; k++) begin
      if (inv_valid != 0 && inv_src == 2'd3) seen.push_back(inv_addr);
      @(negedge clock);
    end
    check("ovf_count", seen.size(), 4);
    for (int i = 0; i < seen.size(); i++) check("ovf_order", seen[i], 16'h3000 + i);

    // INV_SELF build: source core is included.
    do_reset();
    d2_valid[2] = 1'b1; d2_addr[47:32] = 16'h0055; d2_tag[23:16] = 8'h5A;
    @(negedge clock); d2_valid = '0;
    @(negedge clock);
    check("self_valid", d2_inv_valid, 4'b1111);
    check("self_src", d2_inv_src, 2);
    check("self_addr", d2_inv_addr, 16'h0055);

    // Asynchronous reset with work queued.
    do_reset();
    drive(0, 16'h0A00, 8'h0); drive(1, 16'h1000, 8'h1); drive(2, 16'h2000, 8'h2); drive(3, 16'h3000, 8'h3);
    @(negedge clock); chg_valid = 4'b0010; chg_addr[31:16] = 16'h1001;
    @(negedge clock); chg_addr[31:16] = 16'h1002;
    @(negedge clock); chg_valid = '0;
    @(posedge clock); #2;
    check("mid_pre", inv_valid != 0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_drop", inv_valid, 0);
    check("mid_ready_rst", chg_ready, 0);
    @(negedge clock); #2 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("mid_quiet", inv_valid, 0);
    end
    check("mid_ready", chg_ready, 4'hF);

    // Random traffic, including drops on full FIFOs.
    repeat (400) begin
      chg_valid = 4'($urandom) & 4'($urandom);
      chg_addr  = 64'({$urandom, $urandom});
      chg_tag   = 32'($urandom);
      @(negedge clock);
    end
    chg_valid = '0;
    repeat (20) @(negedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
